// File: rtl/hub75_rx_capture_if.sv
// HUB75 receiver bus: panel pins coming in, replayed pixel stream and status going out.
// master = panel driver / stream consumer side, slave = hub75_rx_capture.
interface hub75_rx_capture_if #(
    parameter int NUM_COLS = 64,
    parameter int ROW_BITS = 5
);
    localparam int CW = $clog2(NUM_COLS);

    logic                LP_CLK;
    logic                LATCH;
    logic                NOE;
    logic [ROW_BITS-1:0] ROW;
    logic [2:0]          RGB0;
    logic [2:0]          RGB1;

    logic                px_valid;
    logic                px_ready;
    logic [ROW_BITS-1:0] px_row;
    logic [CW-1:0]       px_col;
    logic [5:0]          px_data;
    logic                line_done;
    logic [CW:0]         line_len;
    logic                row_wrap;
    logic                overflow;
    logic                overrun;
    logic [15:0]         on_time;

    modport master (
        output LP_CLK, LATCH, NOE, ROW, RGB0, RGB1, px_ready,
        input  px_valid, px_row, px_col, px_data, line_done, line_len,
               row_wrap, overflow, overrun, on_time
    );

    modport slave (
        input  LP_CLK, LATCH, NOE, ROW, RGB0, RGB1, px_ready,
        output px_valid, px_row, px_col, px_data, line_done, line_len,
               row_wrap, overflow, overrun, on_time
    );
endinterface

// File: rtl/hub75_rx_capture.sv
// HUB75 receiver: oversampled shift capture into a ping-pong line buffer, replayed per latch as a pixel stream.
// Optional NOE-low on-time counter is built when HUB75_RX_BRIGHT_EN is defined; otherwise on_time reads 0.
module hub75_rx_capture #(
    parameter int NUM_COLS         = 64,
    parameter int ROW_BITS         = 5,
    parameter bit LATCH_ACTIVE_LOW = 1'b1,
    parameter int SYNC_STAGES      = 2
) (
    input  logic              clk,
    input  logic              rst,
    hub75_rx_capture_if.slave bus
);
    localparam int CW   = $clog2(NUM_COLS);
    localparam int IN_W = 3 + ROW_BITS + 6;
    localparam int WU_W = $clog2(SYNC_STAGES + 2) + 1;
    localparam logic [CW:0] FULL = (CW + 1)'(NUM_COLS);

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    // Stage p0: synchroniser chain and edge detection on its last stage
    logic [IN_W-1:0]     sync_p0 [SYNC_STAGES];
    logic                lp_dly_p0;
    logic                latch_dly_p0;
    logic                lp_cur;
    logic                latch_cur;
    logic                noe_cur;
    logic [ROW_BITS-1:0] row_cur;
    logic [5:0]          data_cur;
    logic                latch_edge;

    always_ff @(posedge clk) begin
        sync_p0[0] <= {bus.LP_CLK, bus.LATCH, bus.NOE, bus.ROW, bus.RGB0, bus.RGB1};
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_p0[i] <= sync_p0[i-1];
        end
        lp_dly_p0    <= lp_cur;
        latch_dly_p0 <= latch_cur;
    end

    assign lp_cur     = sync_p0[SYNC_STAGES-1][IN_W-1];
    assign latch_cur  = sync_p0[SYNC_STAGES-1][IN_W-2];
    assign noe_cur    = sync_p0[SYNC_STAGES-1][IN_W-3];
    assign row_cur    = sync_p0[SYNC_STAGES-1][6 +: ROW_BITS];
    assign data_cur   = sync_p0[SYNC_STAGES-1][5:0];
    assign latch_edge = LATCH_ACTIVE_LOW ? (latch_dly_p0 && !latch_cur)
                                         : (!latch_dly_p0 && latch_cur);

    // The chain is not reset, so events are masked until it has filled with real pin samples.
    logic [WU_W-1:0] wu_cnt;
    logic            armed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wu_cnt <= '0;
            armed  <= 1'b0;
        end else if (!armed) begin
            wu_cnt <= wu_cnt + 1'b1;
            if (wu_cnt == WU_W'(SYNC_STAGES)) begin
                armed <= 1'b1;
            end
        end
    end

    // Stage p1: registered events with the pin values that accompany them
    logic                shift_p1;
    logic                latch_p1;
    logic                noe_low_p1;
    logic [5:0]          data_p1;
    logic [ROW_BITS-1:0] row_p1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_p1   <= 1'b0;
            latch_p1   <= 1'b0;
            noe_low_p1 <= 1'b0;
        end else begin
            shift_p1   <= armed && lp_cur && !lp_dly_p0;
            latch_p1   <= armed && latch_edge;
            noe_low_p1 <= armed && !noe_cur;
        end
    end

    always_ff @(posedge clk) begin
        data_p1 <= data_cur;
        row_p1  <= row_cur;
    end

    // Stage p2: capture into the line buffer and drain FSM
    logic [5:0]          bank [2][NUM_COLS];
    state_t              state;
    logic                cap_bank;
    logic                rd_bank;
    logic [CW:0]         wcol;
    logic [CW:0]         len;
    logic [CW:0]         len_now;
    logic [CW-1:0]       rcol;
    logic [ROW_BITS-1:0] row_q;
    logic [ROW_BITS-1:0] prev_row;
    logic                seen_latch;
    logic                wr_en;
    logic                px_valid_q;
    logic                line_done_q;
    logic [CW:0]         line_len_q;
    logic                row_wrap_q;
    logic                overflow_q;
    logic                overrun_q;

    assign wr_en   = shift_p1 && (wcol != FULL);
    // A shift edge coinciding with the latch belongs to the line being latched.
    assign len_now = wcol + {{CW{1'b0}}, wr_en};
    assign rd_bank = ~cap_bank;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            bank[cap_bank][wcol[CW-1:0]] <= data_p1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cap_bank    <= 1'b0;
            wcol        <= '0;
            len         <= '0;
            rcol        <= '0;
            row_q       <= '0;
            prev_row    <= '0;
            seen_latch  <= 1'b0;
            px_valid_q  <= 1'b0;
            line_done_q <= 1'b0;
            line_len_q  <= '0;
            row_wrap_q  <= 1'b0;
            overflow_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            line_done_q <= 1'b0;
            line_len_q  <= '0;
            row_wrap_q  <= 1'b0;

            if (wr_en) begin
                wcol <= wcol + 1'b1;
            end
            if (shift_p1 && !wr_en) begin
                overflow_q <= 1'b1;
            end
            // A latch while the previous line is still out throws the new capture away.
            if (latch_p1 && state != IDLE) begin
                overrun_q <= 1'b1;
                wcol      <= '0;
            end

            case (state)
                IDLE: begin
                    if (latch_p1) begin
                        len        <= len_now;
                        row_q      <= row_p1;
                        prev_row   <= row_p1;
                        seen_latch <= 1'b1;
                        row_wrap_q <= seen_latch && (row_p1 < prev_row);
                        cap_bank   <= ~cap_bank;
                        wcol       <= '0;
                        rcol       <= '0;
                        if (len_now == '0) begin
                            state       <= DONE;
                            line_done_q <= 1'b1;
                        end else begin
                            state      <= DRAIN;
                            px_valid_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (bus.px_ready) begin
                        if ({1'b0, rcol} == len - 1'b1) begin
                            state       <= DONE;
                            px_valid_q  <= 1'b0;
                            line_done_q <= 1'b1;
                            line_len_q  <= len;
                        end else begin
                            rcol <= rcol + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state      <= IDLE;
                    px_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.px_valid  = px_valid_q;
    assign bus.px_row    = row_q;
    assign bus.px_col    = rcol;
    assign bus.px_data   = px_valid_q ? bank[rd_bank][rcol] : 6'd0;
    assign bus.line_done = line_done_q;
    assign bus.line_len  = line_len_q;
    assign bus.row_wrap  = row_wrap_q;
    assign bus.overflow  = overflow_q;
    assign bus.overrun   = overrun_q;

`ifdef HUB75_RX_BRIGHT_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] on_cnt;
    logic [15:0] on_time_q;

    // Snapshot only on latches that start a line, so on_time pairs with that line's line_done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            on_cnt    <= '0;
            on_time_q <= '0;
        end else if (latch_p1 && state == IDLE) begin
            on_time_q <= on_cnt;
            on_cnt    <= '0;
        end else if (noe_low_p1) begin
            on_cnt <= sat_inc(on_cnt);
        end
    end

    assign bus.on_time = on_time_q;
`else
    logic unused_noe;
    assign unused_noe  = noe_low_p1;
    assign bus.on_time = 16'd0;
`endif
endmodule

// File: tb/tb_hub75_rx_capture.sv
// Randomised bench for hub75_rx_capture: drives HUB75 pin waveforms and checks the replayed lines against a line-level model.
module tb_hub75_rx_capture;
    localparam int NUM_COLS    = 64;
    localparam int ROW_BITS    = 5;
    localparam int SYNC_STAGES = 2;
    localparam int CW          = $clog2(NUM_COLS);
`ifdef HUB75_RX_BRIGHT_EN
    localparam bit BRIGHT = 1'b1;
`else
    localparam bit BRIGHT = 1'b0;
`endif

    typedef logic [ROW_BITS-1:0] row_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hub75_rx_capture_if #(.NUM_COLS(NUM_COLS), .ROW_BITS(ROW_BITS)) bus ();

    hub75_rx_capture #(
        .NUM_COLS(NUM_COLS), .ROW_BITS(ROW_BITS),
        .LATCH_ACTIVE_LOW(1'b1), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stream monitor, sampled mid-cycle
    logic [5:0]    got_px  [$];
    logic [CW-1:0] got_col [$];
    row_t          got_row [$];
    int            done_len_q [$];
    int            done_on_q  [$];
    int beat_cnt = 0, done_cnt = 0, wrap_cnt = 0, cyc = 0;
    int first_beat_cyc = -1, last_beat_cyc = -1;
    bit stall_prev = 1'b0;
    logic [31:0] held = '0;

    always @(negedge clk) begin
        cyc++;
        if (stall_prev)
            chk_val("stall_hold", 32'({bus.px_valid, bus.px_row, bus.px_col, bus.px_data}), held);
        stall_prev = bus.px_valid && !bus.px_ready;
        held = 32'({bus.px_valid, bus.px_row, bus.px_col, bus.px_data});
        if (bus.px_valid && bus.px_ready) begin
            got_px.push_back(bus.px_data);
            got_col.push_back(bus.px_col);
            got_row.push_back(bus.px_row);
            beat_cnt++;
            if (first_beat_cyc < 0) first_beat_cyc = cyc;
            last_beat_cyc = cyc;
        end
        if (bus.line_done) begin
            done_len_q.push_back(int'(bus.line_len));
            done_on_q.push_back(int'(bus.on_time));
            done_cnt++;
        end
        if (bus.row_wrap) wrap_cnt++;
    end

    // px_ready pattern: 0 = always high, 1 = toggle, 2 = held low, 3 = random
    int ready_mode = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.px_ready = 1'b1;
                1:       bus.px_ready = ~bus.px_ready;
                2:       bus.px_ready = 1'b0;
                default: bus.px_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic shift_px(input logic [5:0] d);
        bus.RGB0 = d[5:3];
        bus.RGB1 = d[2:0];
        tick(2);
        bus.LP_CLK = 1'b1;
        tick(2);
        bus.LP_CLK = 1'b0;
    endtask

    task automatic latch_row(input row_t r, input bit meas);
        int n;
        bus.ROW = r;
        tick(2);
        bus.LATCH = 1'b0;
        if (meas) begin
            n = 0;
            do begin
                tick(1);
                n++;
            end while (!bus.px_valid && n < 20);
            chk_val("latency", n, SYNC_STAGES + 2);
        end else begin
            tick(2);
        end
        bus.LATCH = 1'b1;
        tick(2);
    endtask

    task automatic wait_done(input int target, input string tag);
        int k = 0;
        while (done_cnt < target && k < 4000) begin
            tick(1);
            k++;
        end
        chk_val({tag, "_done_seen"}, 32'(done_cnt >= target), 1);
    endtask

    // Line-level reference model
    logic [5:0] stim_q [$];
    logic [5:0] exp_px [$];
    row_t  prev_row_m = '0;
    bit    have_prev_m = 1'b0, ovf_m = 1'b0, ovr_m = 1'b0;
    string cur_tag;
    row_t  cur_row;
    int    cur_len, cur_on, base_done, base_wrap, base_beat;
    bit    cur_wrap, cur_consec;

    task automatic start_line(input row_t r, input int exp_on, input bit meas, input string tag);
        cur_tag    = tag;
        cur_row    = r;
        cur_on     = exp_on;
        cur_len    = (stim_q.size() > NUM_COLS) ? NUM_COLS : stim_q.size();
        if (stim_q.size() > NUM_COLS) ovf_m = 1'b1;
        cur_wrap   = have_prev_m && (r < prev_row_m);
        have_prev_m = 1'b1;
        prev_row_m  = r;
        cur_consec = (ready_mode == 0);
        exp_px.delete();
        for (int i = 0; i < cur_len; i++) exp_px.push_back(stim_q[i]);
        base_done = done_cnt;
        base_wrap = wrap_cnt;
        base_beat = beat_cnt;
        got_px.delete();
        got_col.delete();
        got_row.delete();
        first_beat_cyc = -1;
        foreach (stim_q[i]) shift_px(stim_q[i]);
        latch_row(r, meas);
    endtask

    task automatic finish_line();
        int dl, don;
        wait_done(base_done + 1, cur_tag);
        tick(2);
        dl  = -1;
        don = -1;
        if (done_len_q.size() > 0) dl = done_len_q.pop_front();
        if (done_on_q.size() > 0) don = done_on_q.pop_front();
        chk_val({cur_tag, "_len"}, dl, cur_len);
        chk_val({cur_tag, "_on_time"}, don, cur_on);
        chk_val({cur_tag, "_beats"}, beat_cnt - base_beat, cur_len);
        for (int i = 0; i < cur_len; i++) begin
            if (i < got_px.size()) begin
                chk_val({cur_tag, "_data"}, 32'(got_px[i]), 32'(exp_px[i]));
                chk_val({cur_tag, "_col"}, 32'(got_col[i]), i);
                chk_val({cur_tag, "_row"}, 32'(got_row[i]), 32'(cur_row));
            end
        end
        chk_val({cur_tag, "_row_wrap"}, wrap_cnt - base_wrap, 32'(cur_wrap));
        chk_val({cur_tag, "_overflow"}, 32'(bus.overflow), 32'(ovf_m));
        chk_val({cur_tag, "_overrun"}, 32'(bus.overrun), 32'(ovr_m));
        if (cur_consec && cur_len > 0)
            chk_val({cur_tag, "_back_to_back"}, last_beat_cyc - first_beat_cyc, cur_len - 1);
    endtask

    task automatic fill_rand(input int n);
        stim_q.delete();
        for (int i = 0; i < n; i++) stim_q.push_back(6'($urandom_range(0, 63)));
    endtask

    initial begin
        int k;
        row_t rr;
        bus.LP_CLK = 1'b0;
        bus.LATCH  = 1'b1;
        bus.NOE    = 1'b1;
        bus.ROW    = '0;
        bus.RGB0   = '0;
        bus.RGB1   = '0;
        bus.px_ready = 1'b0;
        rst = 1'b0;
        tick(3);
        chk_val("rst_px_valid", 32'(bus.px_valid), 0);
        chk_val("rst_line_done", 32'(bus.line_done), 0);
        chk_val("rst_line_len", 32'(bus.line_len), 0);
        chk_val("rst_row_wrap", 32'(bus.row_wrap), 0);
        chk_val("rst_overflow", 32'(bus.overflow), 0);
        chk_val("rst_overrun", 32'(bus.overrun), 0);
        chk_val("rst_on_time", 32'(bus.on_time), 0);
        chk_val("rst_px_data", 32'(bus.px_data), 0);
        chk_val("rst_px_col", 32'(bus.px_col), 0);
        chk_val("rst_px_row", 32'(bus.px_row), 0);
        rst = 1'b1;
        tick(6);

        // Full 64-pixel ramp on row 5, with latency measurement
        ready_mode = 0;
        stim_q.delete();
        for (int i = 0; i < NUM_COLS; i++) stim_q.push_back(6'(i));
        start_line(row_t'(5), 0, 1'b1, "ramp64");
        finish_line();

        // 70 shift edges: six pixels beyond the buffer are dropped
        fill_rand(70);
        start_line(row_t'($urandom_range(0, 31)), 0, 1'b0, "ovf70");
        finish_line();

        // Alternating back-pressure on a short line
        ready_mode = 1;
        fill_rand(8);
        start_line(row_t'($urandom_range(0, 31)), 0, 1'b0, "toggle8");
        finish_line();

        // Second latch while the first line is stalled mid-drain
        ready_mode = 2;
        tick(2);
        fill_rand(8);
        start_line(row_t'($urandom_range(0, 31)), 0, 1'b0, "ovr_first");
        k = 0;
        while (!bus.px_valid && k < 50) begin
            tick(1);
            k++;
        end
        chk_val("ovr_valid_up", 32'(bus.px_valid), 1);
        for (int i = 0; i < 4; i++) shift_px(6'($urandom_range(0, 63)));
        latch_row(row_t'($urandom_range(0, 31)), 1'b0);
        ovr_m = 1'b1;
        tick(4);
        chk_val("ovr_flag", 32'(bus.overrun), 32'(ovr_m));
        chk_val("ovr_still_draining", done_cnt - base_done, 0);
        ready_mode = 0;
        finish_line();
        tick(40);
        chk_val("ovr_second_dropped", done_cnt - base_done, 1);
        chk_val("ovr_no_extra_px", beat_cnt - base_beat, 8);
        fill_rand(5);
        start_line(row_t'($urandom_range(0, 31)), 0, 1'b0, "ovr_next");
        finish_line();

        // Rows 30, 31, 0: only the last one marks a frame boundary
        for (int j = 0; j < 3; j++) begin
            rr = (j == 0) ? row_t'(30) : (j == 1) ? row_t'(31) : row_t'(0);
            fill_rand($urandom_range(1, 4));
            start_line(rr, 0, 1'b0, "rowseq");
            finish_line();
        end

        // Latch with no shift edges
        stim_q.delete();
        start_line(row_t'($urandom_range(0, 31)), 0, 1'b0, "zero_len");
        finish_line();

        // NOE low for 100 cycles between two latches
        bus.NOE = 1'b0;
        tick(100);
        bus.NOE = 1'b1;
        tick(4);
        fill_rand(3);
        start_line(row_t'($urandom_range(0, 31)), BRIGHT ? 100 : 0, 1'b0, "on_time");
        finish_line();

        // Random lines under random back-pressure
        ready_mode = 3;
        for (int j = 0; j < 6; j++) begin
            fill_rand($urandom_range(0, 72));
            start_line(row_t'($urandom_range(0, 31)), 0, 1'b0, "rand");
            finish_line();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/hub75_rx_capture.md
Name: hub75_rx_capture

Overview:
- Receiving end of the HUB75 panel interface driven by the led_panel_gif driver.
- Oversamples LP_CLK/LATCH/NOE/ROW/RGB0/RGB1 on the system clock and deserialises each shifted row into a ping-pong line buffer.
- On each latch event, replays the captured row as a valid/ready pixel stream with row/column coordinates.
- Used as loopback checker in bench and as on-board capture/monitor feeding a framebuffer.

Parameters:
- NUM_COLS, 64, pixels shifted per row (per half-panel); power of 2.
- ROW_BITS, 5, width of ROW address.
- LATCH_ACTIVE_LOW, 1, 1: latch event = falling edge of LATCH pin; 0: rising edge.
- SYNC_STAGES, 2, synchroniser flops on every panel input (min 2).

Ports:
- clk  in  1  system clock; must be >= 4x LP_CLK frequency.
- rst  in  1  asynchronous, active-low reset.
- LP_CLK  in  1  panel shift clock.
- LATCH  in  1  panel latch strobe.
- NOE  in  1  panel output enable, active-low.
- ROW  in  ROW_BITS  panel row address.
- RGB0  in  3  upper-half colour bits.
- RGB1  in  3  lower-half colour bits.
- px_valid  out  1  pixel stream valid.
- px_ready  in  1  downstream accepts pixel.
- px_row  out  ROW_BITS  row of current pixel.
- px_col  out  $clog2(NUM_COLS)  column of current pixel.
- px_data  out  6  {RGB0,RGB1} of current pixel.
- line_done  out  1  1-cycle pulse after last pixel of a line is accepted.
- line_len  out  $clog2(NUM_COLS)+1  columns in finished line; valid with line_done.
- row_wrap  out  1  1-cycle pulse when latched row < previous latched row (frame boundary).
- overflow  out  1  sticky: more than NUM_COLS shift edges between latches.
- overrun  out  1  sticky: latch arrived while previous line still draining.
- on_time  out  16  NOE-low cycle count of finished line (see Optional Feature).

Behaviour:
- Reset (rst low, async): all outputs 0; wcol=0, capture bank=0, drain FSM=IDLE; sticky flags cleared only by reset.
- All panel inputs pass through SYNC_STAGES flops; edges are detected on the last stage versus a delayed copy.
- Shift capture: on detected LP_CLK rising edge, write {RGB0,RGB1} into capture bank at index wcol; wcol++.
- wcol == NUM_COLS at an edge: no write, overflow<=1, wcol holds.
- Latch event (edge per LATCH_ACTIVE_LOW), drain FSM IDLE:
  - snapshot len=wcol and row=ROW (synchronised).
  - swap banks; wcol<=0; FSM->DRAIN.
  - row_wrap pulses in same cycle if row < previous latched row; first latch after reset never pulses.
- Latch event, FSM not IDLE: overrun<=1; captured line is discarded (wcol<=0, no swap); the draining line is unaffected.
- LP_CLK edge and latch event in the same cycle: the pixel is written first and counted in len.
- Drain FSM states:
  - IDLE: px_valid=0.
  - DRAIN: px_valid=1, px_col=rcol, px_row=snapshot row, px_data=bank[rcol]. Outputs are held stable while px_valid && !px_ready. When px_ready, rcol++; accepting rcol==len-1 -> DONE.
  - DONE: line_done=1 and line_len=len for one cycle; ->IDLE.
- len==0: DRAIN is skipped; IDLE->DONE directly (line_done with line_len=0, no pixels).
- Latency: px_valid rises exactly SYNC_STAGES+2 clk cycles after the LATCH pin edge; one pixel per cycle when px_ready is held high.
- Line buffer: 2 x NUM_COLS x 6 bits, one write port (capture) and one read port (drain); read is combinational or registered, provided the cycle timing above holds.

Optional Feature:
- Macro HUB75_RX_BRIGHT_EN.
- Defined: a 16-bit saturating counter increments each clk with synchronised NOE low. It is snapshotted into on_time at each accepted latch event, then cleared. on_time is valid with the matching line_done.
- Undefined: no counter; on_time tied to 0.

Test Plan:
- Reset, then shift 64 pixels with col c data = c[5:0], ROW=5, latch, px_ready=1 -> 64 consecutive px_valid beats, col 0..63 data 0..63, px_row=5, then line_done with line_len=64; px_valid first seen SYNC_STAGES+2 cycles after latch.
- 70 LP_CLK edges then latch -> overflow=1, line_len=64, pixels 64..69 dropped.
- px_ready toggling 1/0 each cycle on 8-pixel line -> each pixel held stable during stall, all 8 delivered in order, line_done after the 8th acceptance.
- Second latch during drain with px_ready=0 -> overrun=1, first line completes intact, second line never emitted; the next line latched after IDLE is emitted normally.
- Rows latched 30,31,0 -> row_wrap pulse only on row 0; latch with zero shifts -> line_done with line_len=0 and no px_valid.
- HUB75_RX_BRIGHT_EN defined, NOE held low 100 clk cycles between two latches -> on_time=100 with the second line's line_done; undefined -> on_time=0.
